// File: rtl/router_pkg.sv
// Shared NoC types: flit/packet layout, router address, and the ejection-side
// depacketizer FSM and error-classification enums.
package router_pkg;

  localparam int FLIT_SIZE    = 19;
  localparam int NUM_OF_FLITS = 4;
  localparam int PACKET_SIZE  = FLIT_SIZE * NUM_OF_FLITS;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    TAIL      = 2'b01,
    BODY      = 2'b10,
    NONE_FLIT = 2'b11
  } FLIT_TYPE_t;

  typedef struct packed {
    logic       valid;
    FLIT_TYPE_t flit_type;
    logic [15:0] data;
  } FLIT_t;

  // First field lands in the MSBs, so head occupies [75:57].
  typedef struct packed {
    FLIT_t head;
    FLIT_t body1;
    FLIT_t body2;
    FLIT_t tail;
  } PACKET_t;

  typedef struct packed {
    logic [7:0] xaddr;
    logic [7:0] yaddr;
  } ROUTER_CONFIG;

  typedef enum logic [2:0] {
    RX_HEAD  = 3'd0,
    RX_BODY1 = 3'd1,
    RX_BODY2 = 3'd2,
    RX_TAIL  = 3'd3,
    RX_HOLD  = 3'd4
  } RX_STATE_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_NO_HEAD    = 2'd1,
    ERR_EARLY_HEAD = 2'd2,
    ERR_BAD_TYPE   = 2'd3
  } RX_ERR_t;

endpackage

// File: rtl/rx_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module rx_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples its inputs at the same edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/ni_rx_depacketizer.sv
// Ejection side of the network interface: reassembles head/body/body/tail
// flits from the router LOCAL port into one packet for the tile core.
module ni_rx_depacketizer
  import router_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            router_conf,
  input  logic [FLIT_SIZE-1:0]   in_flit,
  output logic                   in_ready,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic [PACKET_SIZE-1:0] pkt_data,
  output logic                   pkt_misrouted,
  output logic [CNT_W-1:0]       pkt_count,
  output logic [CNT_W-1:0]       err_count
);

  FLIT_t        flit;
  ROUTER_CONFIG conf;
  RX_STATE_t    state, state_nxt;
  RX_ERR_t      err_kind;
  PACKET_t      pkt_q;
  logic         misrouted_q;
  logic         flit_acc, handshake;
  logic         store_head, store_body1, store_body2, store_tail;

  assign flit = in_flit;
  assign conf = router_conf;

  // While holding a packet, a new flit can only enter on the handshake cycle.
  assign in_ready  = (state != RX_HOLD) || pkt_ready;
  assign pkt_valid = (state == RX_HOLD);
  assign flit_acc  = flit.valid && in_ready;
  assign handshake = pkt_valid && pkt_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt   = state;
    err_kind    = ERR_NONE;
    store_head  = 1'b0;
    store_body1 = 1'b0;
    store_body2 = 1'b0;
    store_tail  = 1'b0;
    case (state)
      RX_HEAD, RX_HOLD: begin
        if (state == RX_HOLD && handshake && !flit_acc) begin
          state_nxt = RX_HEAD;
        end else if (flit_acc) begin
          if (flit.flit_type == HEAD) begin
            store_head = 1'b1;
            state_nxt  = RX_BODY1;
          end else begin
            err_kind  = ERR_NO_HEAD;
            state_nxt = RX_HEAD;
          end
        end
      end
      RX_BODY1, RX_BODY2, RX_TAIL: begin
        if (flit_acc) begin
          if (flit.flit_type == HEAD) begin
            // A fresh head restarts reassembly rather than being lost.
            err_kind   = ERR_EARLY_HEAD;
            store_head = 1'b1;
            state_nxt  = RX_BODY1;
          end else if (state == RX_BODY1 && flit.flit_type == BODY) begin
            store_body1 = 1'b1;
            state_nxt   = RX_BODY2;
          end else if (state == RX_BODY2 && flit.flit_type == BODY) begin
            store_body2 = 1'b1;
            state_nxt   = RX_TAIL;
          end else if (state == RX_TAIL && flit.flit_type == TAIL) begin
            store_tail = 1'b1;
            state_nxt  = RX_HOLD;
          end else begin
            err_kind  = ERR_BAD_TYPE;
            state_nxt = RX_HEAD;
          end
        end
      end
      default: state_nxt = RX_HEAD;
    endcase
  end

  // NOTE: the packet buffer is reset as well, so pkt_data reads zero out of
  // reset instead of whatever the flops powered up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RX_HEAD;
      pkt_q       <= '0;
      misrouted_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (store_head) begin
        pkt_q.head  <= flit;
        misrouted_q <= (flit.data[15:8] != conf.xaddr) ||
                       (flit.data[7:0]  != conf.yaddr);
      end
      if (store_body1) pkt_q.body1 <= flit;
      if (store_body2) pkt_q.body2 <= flit;
      if (store_tail)  pkt_q.tail  <= flit;
    end
  end

  assign pkt_data      = pkt_q;
  assign pkt_misrouted = misrouted_q;

  rx_sat_counter #(.W(CNT_W)) u_pkt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (handshake),
    .count (pkt_count)
  );

  rx_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (err_kind != ERR_NONE),
    .count (err_count)
  );

endmodule

// File: doc/ni_rx_depacketizer.md
# ni_rx_depacketizer

Local-port ejection side of a tile's network interface. Accepts the 4-flit packet stream (head, body1, body2, tail) leaving a router's LOCAL output port, checks framing and destination address, and presents one reassembled 76-bit packet to the tile core through a valid/ready handshake. It is the receiving counterpart of the tile's packet generator/injector, and keeps saturating packet and error counters for debug.

## Interface
- `FLIT_SIZE`, 19, flit width; `[18]` valid, `[17:16]` FLIT_TYPE_t, `[15:0]` data (head: `[15:8]` xaddr, `[7:0]` yaddr).
- `NUM_OF_FLITS`, 4, flits per packet; fixed framing head/body/body/tail.
- `CNT_W`, 16, width of `pkt_count` and `err_count`.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `router_conf` in 16: ROUTER_CONFIG of this tile (xaddr `[15:8]`, yaddr `[7:0]`); quasi-static.
- `in_flit` in 19: flit from router LOCAL output; a flit is offered when `in_flit[18]`=1.
- `in_ready` out 1: flit accepted on a cycle with `in_flit[18] && in_ready`.
- `pkt_valid` out 1: reassembled packet available.
- `pkt_ready` in 1: core accepts the packet when `pkt_valid && pkt_ready`.
- `pkt_data` out 76: PACKET_t {head, body1, body2, tail}, head in `[75:57]`.
- `pkt_misrouted` out 1: head address differs from `router_conf`; qualified by `pkt_valid`.
- `pkt_count` out CNT_W: delivered packets, saturating.
- `err_count` out CNT_W: framing errors, saturating.

## Operation
- FSM: `RX_HEAD`, `RX_BODY1`, `RX_BODY2`, `RX_TAIL`, `RX_HOLD`. Reset state is `RX_HEAD`.
- `RX_HEAD`: an accepted HEAD flit is stored, address is compared, and the FSM moves to `RX_BODY1`. Any other accepted type is dropped with `err_count`+1.
- `RX_BODY1` and `RX_BODY2`: an accepted BODY is stored and the FSM advances.
- `RX_TAIL`: an accepted TAIL is stored and the FSM moves to `RX_HOLD` (`pkt_valid`=1).
- Unexpected HEAD in `RX_BODY1`, `RX_BODY2` or `RX_TAIL`: abort the partial packet, `err_count`+1, store the new head, go to `RX_BODY1`.
- Unexpected TAIL or NONE_FLIT in `RX_BODY*`, or BODY/NONE_FLIT in `RX_TAIL`: abort, `err_count`+1, go to `RX_HEAD`, flit dropped.
- `in_ready` = 1 in every state except `RX_HOLD`. In `RX_HOLD`, `in_ready` = `pkt_ready`.
- `RX_HOLD`: `pkt_data` and `pkt_misrouted` are held stable until the handshake.
  - On handshake, `pkt_count`+1 (saturating).
  - Same-cycle accepted HEAD goes to `RX_BODY1`.
  - Same-cycle non-HEAD flit is dropped with `err_count`+1, then `RX_HEAD`.
  - Handshake with no flit goes to `RX_HEAD`.
- Misrouted packets are still delivered, with `pkt_misrouted`=1. They do not count as errors.
- Counters stick at all-ones. When an error and a delivery happen in the same cycle, each counter increments independently.

## Timing
- Reset values: `in_ready`=1, `pkt_valid`=0, `pkt_misrouted`=0, `pkt_data`=0, `pkt_count`=0, `err_count`=0. Reset mid-packet discards the partial packet.
- `in_ready` and `pkt_valid` are decoded combinationally from the state register; `in_ready` also depends on `pkt_ready`.
- Latency: tail accepted at edge N gives `pkt_valid`=1 in the cycle after edge N.
- Throughput: one flit per cycle. With `pkt_ready` tied high, back-to-back packets arrive with no bubbles (`RX_HOLD` lasts one cycle).
- `pkt_misrouted` is registered when the head is accepted.

## Structure
- Add to router_pkg:
  - `RX_STATE_t` enum for the FSM states.
  - `RX_ERR_t` enum: `ERR_NONE`, `ERR_NO_HEAD`, `ERR_EARLY_HEAD`, `ERR_BAD_TYPE`, for debug.
  - Reuse the existing FLIT_t, PACKET_t and ROUTER_CONFIG types.
- Sub-module `rx_sat_counter` (parameter W; inputs inc and clear; saturating), instantiated twice.

## Test plan
- Head 0x40102 with `router_conf`=0x0102, then bodies 0x6ABCD and 0x61234, then tail 0x55678, with `pkt_ready`=1. Expect `pkt_valid` one cycle after the tail, `pkt_data`={0x40102,0x6ABCD,0x61234,0x55678}, `pkt_misrouted`=0, `pkt_count`=1.
- Same packet with `pkt_ready`=0 for 5 cycles. Expect `in_ready`=0 and `pkt_data` stable throughout. Release `pkt_ready` in the same cycle a new head arrives: expect the head accepted and state `RX_BODY1`.
- Head 0x40302 with `router_conf`=0x0102. Expect the packet delivered with `pkt_misrouted`=1 and `err_count`=0.
- Body 0x60001 while idle: expect it dropped, `err_count`=1. Then head, body, and a second head: expect `err_count`=2, after which a body, body and tail complete the second packet correctly.
- Assert `rst_n`=0 asynchronously after body1. Expect `pkt_valid`=0 immediately and both counters 0. A following complete packet must be delivered cleanly.
- Force `err_count` to all-ones, then inject a stray tail. Expect `err_count` to stay at 0xFFFF.
